// File: rtl/img_pkg.sv
// Shared definitions for the block-average downscaler pipeline:
// default frame geometry, loader FSM states and the raster address helper.
package img_pkg;

  localparam int unsigned LARGURA_DEF = 4;
  localparam int unsigned ALTURA_DEF  = 4;
  localparam int unsigned PIX_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } loader_state_t;

  // Linear RAM address of a pixel in raster order.
  function automatic int unsigned addr_of(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned width);
    return row * width + col;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame RAM: one synchronous write port, one registered
// read port. Reads beyond DEPTH return 0; a same-cycle write/read to one
// address returns the old contents.
module frame_ram #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_addr,
  input  logic [PIX_W-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [PIX_W-1:0]  o_rd_data
);

  logic [PIX_W-1:0] r_mem [0:DEPTH-1];
  logic [PIX_W-1:0] r_rd_data;
  logic             w_rd_in_range;

  assign w_rd_in_range = (32'(i_rd_addr) < DEPTH);
  assign o_rd_data     = r_rd_data;

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read, zero for out-of-range addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (w_rd_in_range) begin
      r_rd_data <= r_mem[i_rd_addr[IDX_W-1:0]];
    end else begin
      r_rd_data <= '0;
    end
  end

endmodule

// File: rtl/frame_loader.sv
// Upstream stage of the block-average downscaler: captures one raster-scan
// frame into the frame RAM, holds it for the consumer until frame_ack.
// Optional build macro FRAME_SYNC_CHECK_EN enables sof/eol framing checks
// (sticky err_sync, mid-frame sof restarts the frame).
module frame_loader
  import img_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_DEF,
  parameter int unsigned ALTURA  = ALTURA_DEF,
  parameter int unsigned PIX_W   = PIX_W_DEF,
  parameter int unsigned ADDR_W  = $clog2(LARGURA * ALTURA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_sof,
  input  logic              s_eol,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              busy,
  output logic [7:0]        frame_cnt,
  output logic              err_sync
);

  localparam int unsigned DEPTH = LARGURA * ALTURA;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned COL_W = $clog2(LARGURA);
  localparam int unsigned ROW_W = (ALTURA > 1) ? $clog2(ALTURA) : 1;

  loader_state_t r_state, w_state_next;

  logic [COL_W-1:0] r_col, w_col_next;
  logic [ROW_W-1:0] r_row, w_row_next;
  logic             r_s_ready;
  logic             r_busy;
  logic             r_frame_valid;
  logic [7:0]       r_frame_cnt;

  logic             w_xfer;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_addr;
  logic [IDX_W-1:0] w_lin_addr;
  logic             w_cnt_inc;

`ifdef FRAME_SYNC_CHECK_EN
  logic             w_err_set;
  logic             r_err_sync;
`else
  logic             w_unused_eol;
`endif

  assign w_xfer     = s_valid & r_s_ready;
  assign w_last_col = (r_col == COL_W'(LARGURA - 1));
  assign w_last_row = (r_row == ROW_W'(ALTURA - 1));
  assign w_lin_addr = IDX_W'(addr_of(32'(r_row), 32'(r_col), LARGURA));

  assign s_ready     = r_s_ready;
  assign busy        = r_busy;
  assign frame_valid = r_frame_valid;
  assign frame_cnt   = r_frame_cnt;

  // State and raster position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
    end
  end

  // Next state, raster advance and RAM write control.
  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_wr_en      = 1'b0;
    w_wr_addr    = '0;
    w_cnt_inc    = 1'b0;
`ifdef FRAME_SYNC_CHECK_EN
    w_err_set    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        // Beats without sof are consumed and dropped.
        if (w_xfer && s_sof) begin
          w_wr_en      = 1'b1;
          w_wr_addr    = '0;
          w_col_next   = COL_W'(1);
          w_row_next   = '0;
          w_state_next = LOAD;
`ifdef FRAME_SYNC_CHECK_EN
          w_err_set    = s_eol;
`endif
        end
      end
      LOAD: begin
        if (w_xfer) begin
`ifdef FRAME_SYNC_CHECK_EN
          if (s_sof) begin
            // Unexpected sof: flag it and restart the frame at pixel 0.
            w_err_set  = 1'b1;
            w_wr_en    = 1'b1;
            w_wr_addr  = '0;
            w_col_next = COL_W'(1);
            w_row_next = '0;
          end else begin
            w_err_set = (s_eol != w_last_col);
`endif
            w_wr_en   = 1'b1;
            w_wr_addr = w_lin_addr;
            if (w_last_col) begin
              w_col_next = '0;
              if (w_last_row) begin
                w_row_next   = '0;
                w_state_next = FULL;
              end else begin
                w_row_next = r_row + ROW_W'(1);
              end
            end else begin
              w_col_next = r_col + COL_W'(1);
            end
`ifdef FRAME_SYNC_CHECK_EN
          end
`endif
        end
      end
      FULL: begin
        if (frame_ack) begin
          w_state_next = IDLE;
          w_cnt_inc    = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_col_next   = '0;
        w_row_next   = '0;
      end
    endcase
  end

  // Handshake/status outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_ready     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_s_ready     <= (w_state_next != FULL);
      r_busy        <= (w_state_next == LOAD);
      r_frame_valid <= (w_state_next == FULL);
      if (w_cnt_inc) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

`ifdef FRAME_SYNC_CHECK_EN
  // Sticky framing error, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sync <= 1'b0;
    end else if (w_err_set) begin
      r_err_sync <= 1'b1;
    end
  end
  assign err_sync = r_err_sync;
`else
  assign w_unused_eol = s_eol;
  assign err_sync     = 1'b0;
`endif

  frame_ram #(
    .DEPTH  (DEPTH),
    .PIX_W  (PIX_W),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_frame_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (s_data),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

endmodule
